hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core. Decodes the instructions in the D, E and M stages and decides when the front end must freeze.
- When it freezes, it drives the bubble-select into the D→E instruction zeroing mux.
- Tracks the multi-cycle multiply/divide unit with an internal busy counter.
- Purely a decision block: no datapath registers of its own beyond the counter (and the optional statistics counter).

Parameters:
- MULT_CYCLES, 5: busy cycles after mult/multu leaves E.
- DIV_CYCLES, 10: busy cycles after div/divu leaves E.
- CNT_W, 4: busy-counter width. Must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- instr_D  input  32  instruction in ID stage.
- instr_E  input  32  instruction in EX stage (already zeroed if bubbled).
- instr_M  input  32  instruction in MEM stage.
- stall  output  1  freeze PC and IF/ID register.
- flush_E  output  1  bubble select for the D→E zeroing mux; 1 = pass 0.
- md_busy  output  1  multiply/divide unit occupied.

Behaviour:
Clocking, reset and outputs:
- One clock (clk). Reset is synchronous and active-high (reset).
- While reset=1, stall=0, flush_E=0 and md_busy=0 are forced. On the reset edge the busy counter cnt clears to 0.
- stall, flush_E and md_busy are combinational from the instr_* inputs and cnt, with zero-cycle latency.
- flush_E == stall at all times.
- stall = H1 | H2 | H3 | H4 (defined below).

Decode classes (op = [31:26], funct = [5:0], rs = [25:21], rt = [20:16], rd = [15:11]):
- load: op ∈ {0x20, 0x21, 0x23, 0x24, 0x25}; dest = rt.
- store: op ∈ {0x28, 0x29, 0x2B}; reads rs and rt.
- br: beq/bne (op 4/5) read rs and rt; blez/bgtz (op 6/7) read rs; jr/jalr (op 0, funct 8/9) read rs.
- alu_i: op 0x08–0x0E, reads rs, dest = rt. lui (0x0F) has dest rt and reads nothing.
- R-type (op 0):
  - funct 0x20–0x2B and shifts-by-reg (4, 6, 7) read rs and rt, dest = rd.
  - sll/srl/sra (0, 2, 3) read rt only, dest = rd.
  - mfhi/mflo (0x10/0x12) dest = rd, read nothing.
  - mthi/mtlo (0x11/0x13) read rs.
  - mult/multu/div/divu (0x18–0x1B) read rs and rt.
  - jalr dest = rd.
- jal (op 3): dest = 31.
- md: funct 0x10–0x13 or 0x18–0x1B with op 0.
- A dest of $0 never creates a hazard. The all-zero instruction (bubble) matches nothing.

Hazards:
- H1 load-use: instr_E is load, and its dest equals a register read by instr_D.
- H2 branch vs E: instr_D is br, and instr_E has a nonzero dest equal to a register read by instr_D (any writer, including load).
- H3 branch vs M-load: instr_D is br, instr_M is load, and its dest equals a register read by instr_D.
- H4 md-use: instr_D is md and md_busy=1.

Busy counter:
- Each edge, with reset=0:
  - If instr_E is mult/multu, cnt ← MULT_CYCLES.
  - Else if instr_E is div/divu, cnt ← DIV_CYCLES.
  - Else if cnt != 0, cnt ← cnt−1.
- cnt saturates at 0. It never wraps.
- md_busy = (cnt != 0) | (instr_E is mult/multu/div/divu).
- A new md start in E while cnt != 0 cannot occur under H4. If forced by a testbench, the counter reloads (newest op wins).
- Reset mid-operation clears cnt immediately; md_busy is 0 in the cycle after the reset edge.

Simultaneous hazards:
- Multiple hazards asserted together produce a single stall; there is no priority effect on the outputs.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - Adds output port stall_cnt [31:0].
  - Increments by 1 on every edge where stall=1 and reset=0. Wraps from 0xFFFFFFFF to 0.
  - Clears to 0 on reset.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Load-use: instr_E = lw $8,0($1) (0x8C280000), instr_D = add $9,$8,$2 (0x01024820) → stall=flush_E=1. Change instr_D to use $10 instead → stall=0.
- $0 destination: instr_E = lw $0,0($1) with instr_D reading $0 → stall=0.
- Branch vs ALU in E: instr_E = addu $4,$5,$6, instr_D = beq $4,$7 → stall=1. Then move the addu to M with instr_E=0 → stall=0.
- Branch vs M-load: instr_M = lw $3, instr_D = jr $3 → stall=1. instr_M = addu $3 instead → stall=0.
- Multiply busy: mult in E at cycle t, then mflo held in D → md_busy and stall high for cycles t..t+5 (6 cycles), low at t+6. Repeat with div → high for 11 cycles.
- Reset mid-busy: assert reset 2 cycles after div enters E → stall=0 during reset and md_busy=0 after release. With HAZARD_STATS_EN defined, stall_cnt reads 0 after reset and equals the counted stall cycles otherwise.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use, branch-operand and mul/div-busy stalls.
// Optional stall statistics counter enabled by HAZARD_STATS_EN.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_D,
    input  logic [31:0] instr_E,
    input  logic [31:0] instr_M,
    output logic        stall,
    output logic        flush_E,
    output logic        md_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    typedef struct packed {
        logic       rd_rs;
        logic       rd_rt;
        logic [4:0] dst;
        logic       ld;
        logic       br;
        logic       md;
        logic       mul;
        logic       dv;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t       d;
        logic [5:0] op;
        logic [5:0] fn;
        d  = '0;
        op = ins[31:26];
        fn = ins[5:0];
        if (ins != 32'd0) begin
            if (op == 6'h00) begin
                if ((fn >= 6'h20 && fn <= 6'h2B) || fn == 6'h04 ||
                    fn == 6'h06 || fn == 6'h07) begin
                    d.rd_rs = 1'b1;
                    d.rd_rt = 1'b1;
                    d.dst   = ins[15:11];
                end else if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) begin
                    d.rd_rt = 1'b1;
                    d.dst   = ins[15:11];
                end else if (fn == 6'h10 || fn == 6'h12) begin
                    d.dst = ins[15:11];
                    d.md  = 1'b1;
                end else if (fn == 6'h11 || fn == 6'h13) begin
                    d.rd_rs = 1'b1;
                    d.md    = 1'b1;
                end else if (fn >= 6'h18 && fn <= 6'h1B) begin
                    d.rd_rs = 1'b1;
                    d.rd_rt = 1'b1;
                    d.md    = 1'b1;
                    d.mul   = (fn[1] == 1'b0);
                    d.dv    = (fn[1] == 1'b1);
                end else if (fn == 6'h08) begin
                    d.rd_rs = 1'b1;
                    d.br    = 1'b1;
                end else if (fn == 6'h09) begin
                    d.rd_rs = 1'b1;
                    d.br    = 1'b1;
                    d.dst   = ins[15:11];
                end
            end else if (op == 6'h04 || op == 6'h05) begin
                d.rd_rs = 1'b1;
                d.rd_rt = 1'b1;
                d.br    = 1'b1;
            end else if (op == 6'h06 || op == 6'h07) begin
                d.rd_rs = 1'b1;
                d.br    = 1'b1;
            end else if (op == 6'h03) begin
                d.dst = 5'd31;
            end else if (op >= 6'h08 && op <= 6'h0E) begin
                d.rd_rs = 1'b1;
                d.dst   = ins[20:16];
            end else if (op == 6'h0F) begin
                d.dst = ins[20:16];
            end else if (op == 6'h20 || op == 6'h21 || op == 6'h23 ||
                         op == 6'h24 || op == 6'h25) begin
                // base register is a real source operand of the address add
                d.rd_rs = 1'b1;
                d.dst   = ins[20:16];
                d.ld    = 1'b1;
            end else if (op == 6'h28 || op == 6'h29 || op == 6'h2B) begin
                d.rd_rs = 1'b1;
                d.rd_rt = 1'b1;
            end
        end
        return d;
    endfunction

    // True when instruction ins (decoded as d) reads register r; $0 never counts.
    function automatic logic reads(input dec_t d, input logic [31:0] ins,
                                   input logic [4:0] r);
        return (r != 5'd0) &&
               ((d.rd_rs && ins[25:21] == r) || (d.rd_rt && ins[20:16] == r));
    endfunction

    dec_t             dec_d;
    dec_t             dec_e;
    dec_t             dec_m;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             busy;
    logic             h1;
    logic             h2;
    logic             h3;
    logic             h4;

    // Decode the three stages and evaluate every hazard term.
    always_comb begin
        dec_d = decode(instr_D);
        dec_e = decode(instr_E);
        dec_m = decode(instr_M);
        busy  = (cnt_q != '0) | dec_e.mul | dec_e.dv;
        h1    = dec_e.ld && reads(dec_d, instr_D, dec_e.dst);
        h2    = dec_d.br && reads(dec_d, instr_D, dec_e.dst);
        h3    = dec_d.br && dec_m.ld && reads(dec_d, instr_D, dec_m.dst);
        h4    = dec_d.md && busy;
        stall   = ~reset & (h1 | h2 | h3 | h4);
        flush_E = stall;
        md_busy = ~reset & busy;
    end

    // Busy counter next state: newest mul/div in E reloads, else count down.
    always_comb begin
        cnt_d = cnt_q;
        if (dec_e.mul) begin
            cnt_d = CNT_W'(MULT_CYCLES);
        end else if (dec_e.dv) begin
            cnt_d = CNT_W'(DIV_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Busy counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q;

    // Count stalled cycles, wrapping naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
